// File: rtl/llbit_pkg.sv
// Shared types and defaults for the LL/SC reservation monitor: state encoding,
// default parameter values and granule/channel width helpers.
package llbit_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    RESERVED = 1'b1
  } llbit_state_e;

  localparam int DEF_N_CH     = 2;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_GRAN_LSB = 2;
  localparam int DEF_TIMEOUT  = 255;

  // Number of address bits that take part in a granule compare.
  function automatic int gran_w(input int addr_w, input int gran_lsb);
    return addr_w - gran_lsb;
  endfunction

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/llbit_entry.sv
// One reservation channel: IDLE/RESERVED state, stored granule, SC/store match.
// Zero-latency match output; optional lifetime counter under LLSC_TIMEOUT_EN.
module llbit_entry
  import llbit_pkg::*;
#(
  parameter int GW      = 30,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_ll,
  input  logic [GW-1:0] i_ll_gran,
  input  logic          i_clr,
  input  logic          i_st_vld,
  input  logic [GW-1:0] i_st_gran,
  input  logic [GW-1:0] i_sc_gran,
  output logic          o_llbit,
  output logic          o_sc_hit
);

  llbit_state_e  r_state;
  llbit_state_e  w_state_nxt;
  logic [GW-1:0] r_gran;
  logic          w_st_hit;
  logic          w_timeout;

  assign o_llbit  = (r_state == RESERVED);
  assign o_sc_hit = o_llbit && (r_gran == i_sc_gran);
  assign w_st_hit = i_st_vld && o_llbit && (r_gran == i_st_gran);

  // flush beats LL, and LL beats every clearing event on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = IDLE;
    end else if (i_ll) begin
      w_state_nxt = RESERVED;
    end else if (i_clr || w_st_hit || w_timeout) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gran  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!i_flush && i_ll) begin
        r_gran <= i_ll_gran;
      end
    end
  end

`ifdef LLSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = o_llbit && (w_cnt_inc == CW'(TIMEOUT));

  always_comb begin
    w_cnt_nxt = '0;
    if (w_state_nxt == RESERVED && !i_ll) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: rtl/llbit_monitor.sv
// LL/SC reservation monitor: per-channel reservations, store snoop, SC result 1 cycle later.
// No backpressure; optional reservation timeout under macro LLSC_TIMEOUT_EN.
module llbit_monitor
  import llbit_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GRAN_LSB = DEF_GRAN_LSB,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ll_valid_i,
  input  logic [ch_w(N_CH)-1:0]   ll_ch_i,
  input  logic [ADDR_W-1:0]       ll_addr_i,
  input  logic                    sc_valid_i,
  input  logic [ch_w(N_CH)-1:0]   sc_ch_i,
  input  logic [ADDR_W-1:0]       sc_addr_i,
  input  logic                    st_valid_i,
  input  logic [ADDR_W-1:0]       st_addr_i,
  output logic                    sc_done_o,
  output logic                    sc_success_o,
  output logic [N_CH-1:0]         llbit_o
);

  localparam int CH_W = ch_w(N_CH);
  localparam int GW   = gran_w(ADDR_W, GRAN_LSB);

  logic [CH_W:0]   w_n_ch;
  logic            w_ll_ok;
  logic            w_sc_ok;
  logic            w_sc_succ;
  logic [N_CH-1:0] w_sc_hit;
  logic [N_CH-1:0] w_ll_set;
  logic [N_CH-1:0] w_clr;
  logic            r_sc_done;
  logic            r_sc_success;
  logic            w_unused_lsb;

  assign w_n_ch  = (CH_W + 1)'(N_CH);
  assign w_ll_ok = ll_valid_i && ({1'b0, ll_ch_i} < w_n_ch);
  assign w_sc_ok = sc_valid_i && ({1'b0, sc_ch_i} < w_n_ch);

  // SC result uses start-of-cycle state; a winning SC also behaves as a store.
  assign w_sc_succ = w_sc_ok && w_sc_hit[sc_ch_i];

  assign w_unused_lsb = ^{ll_addr_i[GRAN_LSB-1:0], sc_addr_i[GRAN_LSB-1:0],
                          st_addr_i[GRAN_LSB-1:0], TIMEOUT[0]};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_ll_set[g] = w_ll_ok && (ll_ch_i == CH_W'(g));
    assign w_clr[g]    = (w_sc_ok && (sc_ch_i == CH_W'(g))) || (w_sc_succ && w_sc_hit[g]);

    llbit_entry #(
      .GW      (GW),
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (flush),
      .i_ll      (w_ll_set[g]),
      .i_ll_gran (ll_addr_i[ADDR_W-1:GRAN_LSB]),
      .i_clr     (w_clr[g]),
      .i_st_vld  (st_valid_i),
      .i_st_gran (st_addr_i[ADDR_W-1:GRAN_LSB]),
      .i_sc_gran (sc_addr_i[ADDR_W-1:GRAN_LSB]),
      .o_llbit   (llbit_o[g]),
      .o_sc_hit  (w_sc_hit[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc_done    <= 1'b0;
      r_sc_success <= 1'b0;
    end else begin
      r_sc_done    <= sc_valid_i && !flush;
      r_sc_success <= w_sc_succ && !flush;
    end
  end

  assign sc_done_o    = r_sc_done;
  assign sc_success_o = r_sc_success;

endmodule

// File: tb/tb_llbit_monitor.sv
// Directed bench for llbit_monitor: vector table plus async-reset and lifetime sequences.
module tb_llbit_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ll_valid_i = 1'b0;
  logic [0:0]  ll_ch_i = '0;
  logic [31:0] ll_addr_i = '0;
  logic        sc_valid_i = 1'b0;
  logic [0:0]  sc_ch_i = '0;
  logic [31:0] sc_addr_i = '0;
  logic        st_valid_i = 1'b0;
  logic [31:0] st_addr_i = '0;
  logic        sc_done_o;
  logic        sc_success_o;
  logic [1:0]  llbit_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LLSC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  llbit_monitor #(
    .N_CH     (2),
    .ADDR_W   (32),
    .GRAN_LSB (2),
    .TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ll_valid_i   (ll_valid_i),
    .ll_ch_i      (ll_ch_i),
    .ll_addr_i    (ll_addr_i),
    .sc_valid_i   (sc_valid_i),
    .sc_ch_i      (sc_ch_i),
    .sc_addr_i    (sc_addr_i),
    .st_valid_i   (st_valid_i),
    .st_addr_i    (st_addr_i),
    .sc_done_o    (sc_done_o),
    .sc_success_o (sc_success_o),
    .llbit_o      (llbit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        llv;
    logic        llc;
    logic [31:0] lla;
    logic        scv;
    logic        scc;
    logic [31:0] sca;
    logic        stv;
    logic [31:0] sta;
    logic        done;
    logic        succ;
    logic [1:0]  llb;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic fl, logic llv, logic llc, logic [31:0] lla,
                              logic scv, logic scc, logic [31:0] sca,
                              logic stv, logic [31:0] sta,
                              logic done, logic succ, logic [1:0] llb);
    vec_t v;
    v.fl = fl; v.llv = llv; v.llc = llc; v.lla = lla;
    v.scv = scv; v.scc = scc; v.sca = sca;
    v.stv = stv; v.sta = sta;
    v.done = done; v.succ = succ; v.llb = llb;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, check just after the rising edge.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    flush      = v.fl;
    ll_valid_i = v.llv; ll_ch_i = v.llc; ll_addr_i = v.lla;
    sc_valid_i = v.scv; sc_ch_i = v.scc; sc_addr_i = v.sca;
    st_valid_i = v.stv; st_addr_i = v.sta;
    @(posedge clk);
    #1;
    check({nm, " sc_done"},    {31'b0, sc_done_o},    {31'b0, v.done});
    check({nm, " sc_success"}, {31'b0, sc_success_o}, {31'b0, v.succ});
    check({nm, " llbit"},      {30'b0, llbit_o},      {30'b0, v.llb});
  endtask

  vec_t idle_v;

  initial begin
    idle_v = mk(0, 0,0,0, 0,0,0, 0,0, 0,0,2'b00);

    //               fl llv c  lla       scv c  sca       stv sta       dn sx llb
    vecs[0]  = mk(0, 1,0,32'h1000, 0,0,32'h0,    0,32'h0,    0,0,2'b01);
    vecs[1]  = mk(0, 0,0,32'h0,    1,0,32'h1000, 0,32'h0,    1,1,2'b00);
    vecs[2]  = mk(0, 1,0,32'h1000, 0,0,32'h0,    0,32'h0,    0,0,2'b01);
    vecs[3]  = mk(0, 0,0,32'h0,    0,0,32'h0,    1,32'h1002, 0,0,2'b00);
    vecs[4]  = mk(0, 0,0,32'h0,    1,0,32'h1000, 0,32'h0,    1,0,2'b00);
    vecs[5]  = mk(0, 1,0,32'h1000, 0,0,32'h0,    0,32'h0,    0,0,2'b01);
    vecs[6]  = mk(0, 0,0,32'h0,    0,0,32'h0,    1,32'h1004, 0,0,2'b01);
    vecs[7]  = mk(0, 0,0,32'h0,    1,0,32'h1000, 0,32'h0,    1,1,2'b00);
    vecs[8]  = mk(0, 1,0,32'h2000, 0,0,32'h0,    0,32'h0,    0,0,2'b01);
    vecs[9]  = mk(0, 1,1,32'h2000, 0,0,32'h0,    0,32'h0,    0,0,2'b11);
    vecs[10] = mk(0, 0,0,32'h0,    1,1,32'h2000, 0,32'h0,    1,1,2'b00);
    vecs[11] = mk(0, 0,0,32'h0,    1,0,32'h2000, 0,32'h0,    1,0,2'b00);
    vecs[12] = mk(0, 1,1,32'h3000, 0,0,32'h0,    0,32'h0,    0,0,2'b10);
    vecs[13] = mk(1, 0,0,32'h0,    1,1,32'h3000, 0,32'h0,    0,0,2'b00);
    vecs[14] = mk(0, 1,0,32'h4000, 0,0,32'h0,    1,32'h4000, 0,0,2'b01);
    vecs[15] = mk(0, 0,0,32'h0,    1,0,32'h4003, 0,32'h0,    1,1,2'b00);
    vecs[16] = mk(0, 1,1,32'h5000, 0,0,32'h0,    0,32'h0,    0,0,2'b10);
    vecs[17] = mk(0, 1,0,32'h6000, 0,0,32'h0,    0,32'h0,    0,0,2'b11);
    vecs[18] = mk(0, 0,0,32'h0,    0,0,32'h0,    1,32'h5008, 0,0,2'b11);
    vecs[19] = mk(0, 0,0,32'h0,    1,0,32'h5000, 0,32'h0,    1,0,2'b10);
    vecs[20] = mk(0, 0,0,32'h0,    1,1,32'h5000, 0,32'h0,    1,1,2'b00);
    vecs[21] = mk(0, 0,0,32'h0,    1,1,32'h5000, 0,32'h0,    1,0,2'b00);
    vecs[22] = mk(0, 1,0,32'h7000, 0,0,32'h0,    0,32'h0,    0,0,2'b01);
    vecs[23] = mk(0, 1,0,32'h8000, 1,0,32'h7000, 0,32'h0,    1,1,2'b01);
    vecs[24] = mk(0, 0,0,32'h0,    1,0,32'h8000, 0,32'h0,    1,1,2'b00);
    vecs[25] = mk(0, 1,1,32'h9000, 0,0,32'h0,    0,32'h0,    0,0,2'b10);
    vecs[26] = mk(0, 1,0,32'h9000, 1,1,32'h9000, 0,32'h0,    1,1,2'b01);
    vecs[27] = mk(1, 0,0,32'h0,    0,0,32'h0,    0,32'h0,    0,0,2'b00);

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("reset sc_done",    {31'b0, sc_done_o},    32'h0);
    check("reset sc_success", {31'b0, sc_success_o}, 32'h0);
    check("reset llbit",      {30'b0, llbit_o},      32'h0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges with both channels reserved.
    apply(mk(0, 1,0,32'hA000, 0,0,0, 0,0, 0,0,2'b01), "arst ll0");
    apply(mk(0, 1,1,32'hA000, 0,0,0, 0,0, 0,0,2'b11), "arst ll1");
    apply(mk(0, 0,0,0, 1,0,32'hA004, 0,0, 1,0,2'b10), "arst sc miss");
    #2;
    rst = 1'b1;
    #1;
    check("arst llbit immediate",   {30'b0, llbit_o},   32'h0);
    check("arst sc_done immediate", {31'b0, sc_done_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 1,1,32'hB000, 0,0,0, 0,0, 0,0,2'b10), "post-rst ll1");
    apply(mk(0, 0,0,0, 1,1,32'hB000, 0,0, 1,1,2'b00), "post-rst sc1");

    // Reservation lifetime: expires on the 4th edge after LL only with the timeout build.
    apply(mk(0, 1,0,32'hC000, 0,0,0, 0,0, 0,0,2'b01), "life ll0");
    for (int i = 1; i <= 3; i++) begin
      apply(idle_v.llb == 2'b00 ? mk(0, 0,0,0, 0,0,0, 0,0, 0,0,2'b01) : idle_v,
            $sformatf("life idle%0d", i));
    end
    apply(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, TO_EN ? 2'b00 : 2'b01), "life idle4");
    apply(mk(0, 0,0,0, 1,0,32'hC000, 0,0, 1, !TO_EN, 2'b00), "life sc0");

    apply(idle_v, "final idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
